// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state codes and delay-slot indices for the alarm core
package alarm_pkg;

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        DISARMED   = 3'd1,
        TRIGGERED  = 3'd2,
        ALARM_ON   = 3'd3,
        ALARM_HOLD = 3'd4,
        LOCKOUT    = 3'd5
    } main_state_t;

    typedef enum logic [1:0] {
        WAIT_IGN_OFF    = 2'd0,
        WAIT_DOOR_OPEN  = 2'd1,
        WAIT_DOOR_CLOSE = 2'd2,
        ARM_DELAY       = 2'd3
    } arm_seq_t;

    localparam logic [1:0] SLOT_ARM = 2'd0;
    localparam logic [1:0] SLOT_DRV = 2'd1;
    localparam logic [1:0] SLOT_PAS = 2'd2;
    localparam logic [1:0] SLOT_ON  = 2'd3;

endpackage

// File: rtl/alarm_countdown.sv
// rtl/alarm_countdown.sv - seconds countdown with load, tick and expiry pulse
module alarm_countdown #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] load_eff;

    // a zero delay would never expire, so it is stretched to one second
    assign load_eff = (load_value == '0) ? CNT_W'(1) : load_value;

    // expiry is the tick that takes the count from 1 to 0
    assign expired = tick && !clear && !load && (count == CNT_W'(1));

    // clear beats load, load beats tick; the count parks at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_eff;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// rtl/alarm_zone_ctrl.sv - anti-theft alarm core: zones, delay bank, arm sequencer, lockout
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ZONES    = 2,
    parameter int CNT_W      = 4,
    parameter int T_ARM_DEF  = 6,
    parameter int T_DRV_DEF  = 8,
    parameter int T_PAS_DEF  = 15,
    parameter int T_ON_DEF   = 10,
    parameter int MAX_CYCLES = 3,
    localparam int ZONE_W    = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick_1hz,
    input  logic               ignition,
    input  logic [N_ZONES-1:0] doors,
    input  logic               reprogram,
    input  logic [1:0]         sel,
    input  logic [CNT_W-1:0]   value,
    output logic [2:0]         state,
    output logic               status,
    output logic               siren_en,
    output logic [ZONE_W-1:0]  zone,
    output logic [CNT_W-1:0]   countdown
);

    main_state_t       state_q, state_d;
    arm_seq_t          arm_q, arm_d;
    logic [2:0]        cycles_q, cycles_d;
    logic [ZONE_W-1:0] zone_q, zone_d, low_zone;
    logic [CNT_W-1:0]  slot_q [4];
    logic              load, clear, expired, any_open;
    logic [1:0]        load_slot;

    assign any_open = |doors;

    // delay bank: reprogram stores at least one second so a slot never holds zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q[SLOT_ARM] <= CNT_W'(T_ARM_DEF);
            slot_q[SLOT_DRV] <= CNT_W'(T_DRV_DEF);
            slot_q[SLOT_PAS] <= CNT_W'(T_PAS_DEF);
            slot_q[SLOT_ON]  <= CNT_W'(T_ON_DEF);
        end else if (reprogram) begin
            slot_q[sel] <= (value == '0) ? CNT_W'(1) : value;
        end
    end

    // lowest-numbered open door names the trigger zone
    always_comb begin
        low_zone = '0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            if (doors[i]) low_zone = ZONE_W'(i);
        end
    end

    alarm_countdown #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .load       (load),
        .load_value (slot_q[load_slot]),
        .tick       (tick_1hz),
        .count      (countdown),
        .expired    (expired)
    );

    // state, arm sequencer, cycle counter and trigger zone registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARMED;
            arm_q    <= WAIT_IGN_OFF;
            cycles_q <= '0;
            zone_q   <= '0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            cycles_q <= cycles_d;
            zone_q   <= zone_d;
        end
    end

    // next state, timer loads and sequencer steps; reprogram overrides everything
    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        cycles_d  = cycles_q;
        zone_d    = zone_q;
        load      = 1'b0;
        load_slot = SLOT_ARM;
        clear     = 1'b0;
        if (reprogram) begin
            state_d  = ARMED;
            arm_d    = WAIT_IGN_OFF;
            cycles_d = '0;
            clear    = 1'b1;
        end else begin
            case (state_q)
                ARMED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (any_open) begin
                        state_d   = TRIGGERED;
                        zone_d    = low_zone;
                        load      = 1'b1;
                        load_slot = (low_zone == '0) ? SLOT_DRV : SLOT_PAS;
                    end
                end
                DISARMED: begin
                    if ((arm_q == ARM_DELAY) && expired) begin
                        state_d  = ARMED;
                        cycles_d = '0;
                    end else if (ignition) begin
                        arm_d = WAIT_IGN_OFF;
                    end else begin
                        case (arm_q)
                            WAIT_IGN_OFF:    arm_d = WAIT_DOOR_OPEN;
                            WAIT_DOOR_OPEN:  if (doors[0]) arm_d = WAIT_DOOR_CLOSE;
                            WAIT_DOOR_CLOSE: begin
                                if (!any_open) begin
                                    arm_d     = ARM_DELAY;
                                    load      = 1'b1;
                                    load_slot = SLOT_ARM;
                                end
                            end
                            default:         if (any_open) arm_d = WAIT_DOOR_CLOSE;
                        endcase
                    end
                end
                TRIGGERED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (expired) begin
                        state_d = ALARM_ON;
                        if (cycles_q != 3'(MAX_CYCLES)) cycles_d = cycles_q + 3'd1;
                    end
                end
                ALARM_ON: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (!any_open) begin
                        state_d   = ALARM_HOLD;
                        load      = 1'b1;
                        load_slot = SLOT_ON;
                    end
                end
                ALARM_HOLD: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (any_open) begin
                        state_d = ALARM_ON;
                    end else if (expired) begin
                        if (cycles_q == 3'(MAX_CYCLES)) state_d = LOCKOUT;
                        else                            state_d = ARMED;
                    end
                end
                LOCKOUT: begin
                    if (ignition) state_d = DISARMED;
                end
                default: state_d = ARMED;
            endcase
            // fresh disarm restarts the arm sequence and forgets past alarm cycles
            if ((state_d == DISARMED) && (state_q != DISARMED)) begin
                cycles_d = '0;
            end
            if ((state_d != DISARMED) || (state_q != DISARMED)) begin
                arm_d = WAIT_IGN_OFF;
            end
        end
    end

    assign state    = state_q;
    assign status   = (state_q == ARMED) || (state_q == LOCKOUT);
    assign siren_en = (state_q == ALARM_ON) || (state_q == ALARM_HOLD);
    assign zone     = zone_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb/tb_alarm_zone_ctrl.sv - directed and randomized checks of alarm_zone_ctrl against a behavioural model
module tb_alarm_zone_ctrl;
    import alarm_pkg::*;

    localparam int N    = 2;
    localparam int CW   = 4;
    localparam int MAXC = 3;
    localparam int A_IGN_OFF = 0, A_OPEN = 1, A_CLOSE = 2, A_DELAY = 3;

    logic          clock = 1'b0, reset_n = 1'b0, tick_1hz = 1'b0, ignition = 1'b0, reprogram = 1'b0;
    logic [N-1:0]  doors = '0;
    logic [4:0]    doors5 = '0;
    logic [1:0]    sel = '0;
    logic [CW-1:0] value = '0;

    logic [2:0]    state, state5, state1;
    logic          status, siren_en, status5, siren5, status1, siren1;
    logic [0:0]    zone, zone1;
    logic [2:0]    zone5;
    logic [CW-1:0] countdown, countdown5, countdown1;

    int checks = 0;
    int errors = 0;

    alarm_zone_ctrl u_dut (
        .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz), .ignition(ignition),
        .doors(doors), .reprogram(reprogram), .sel(sel), .value(value),
        .state(state), .status(status), .siren_en(siren_en), .zone(zone), .countdown(countdown)
    );

    alarm_zone_ctrl #(.N_ZONES(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz), .ignition(ignition),
        .doors(doors5), .reprogram(reprogram), .sel(sel), .value(value),
        .state(state5), .status(status5), .siren_en(siren5), .zone(zone5), .countdown(countdown5)
    );

    alarm_zone_ctrl #(.N_ZONES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .tick_1hz(tick_1hz), .ignition(ignition),
        .doors(doors[0:0]), .reprogram(reprogram), .sel(sel), .value(value),
        .state(state1), .status(status1), .siren_en(siren1), .zone(zone1), .countdown(countdown1)
    );

    always #5 clock = ~clock;

    main_state_t m_state;
    int m_arm, m_cnt, m_cycles, m_zone;
    int m_slot [4];

    task automatic model_reset();
        m_state  = ARMED;
        m_arm    = A_IGN_OFF;
        m_cnt    = 0;
        m_cycles = 0;
        m_zone   = 0;
        m_slot   = '{6, 8, 15, 10};
    endtask

    task automatic model_step();
        int  low, cnt_next;
        bit  open, hit_zero;
        open = (doors != '0);
        if (reprogram) begin
            m_slot[sel] = (value == 0) ? 1 : int'(value);
            m_state = ARMED; m_arm = A_IGN_OFF; m_cnt = 0; m_cycles = 0;
            return;
        end
        hit_zero = tick_1hz && (m_cnt == 1);
        cnt_next = (tick_1hz && m_cnt > 0) ? m_cnt - 1 : m_cnt;
        low = 0;
        for (int i = N - 1; i >= 0; i--) if (doors[i]) low = i;
        if (ignition && m_state != DISARMED) begin
            m_state = DISARMED; m_arm = A_IGN_OFF; m_cycles = 0;
        end else begin
            case (m_state)
                ARMED: if (open) begin
                    m_state = TRIGGERED; m_zone = low; cnt_next = m_slot[(low == 0) ? 1 : 2];
                end
                DISARMED: begin
                    if (m_arm == A_DELAY && hit_zero) begin m_state = ARMED; m_cycles = 0; end
                    else if (ignition) m_arm = A_IGN_OFF;
                    else if (m_arm == A_IGN_OFF) m_arm = A_OPEN;
                    else if (m_arm == A_OPEN && doors[0]) m_arm = A_CLOSE;
                    else if (m_arm == A_CLOSE && !open) begin m_arm = A_DELAY; cnt_next = m_slot[0]; end
                    else if (m_arm == A_DELAY && open) m_arm = A_CLOSE;
                end
                TRIGGERED: if (hit_zero) begin
                    m_state = ALARM_ON;
                    if (m_cycles < MAXC) m_cycles++;
                end
                ALARM_ON: if (!open) begin m_state = ALARM_HOLD; cnt_next = m_slot[3]; end
                ALARM_HOLD: begin
                    if (open) m_state = ALARM_ON;
                    else if (hit_zero) begin
                        if (m_cycles == MAXC) m_state = LOCKOUT;
                        else                  m_state = ARMED;
                    end
                end
                default: ;
            endcase
        end
        m_cnt = cnt_next;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clock) begin
        logic e_status, e_siren;
        e_status = (m_state == ARMED) || (m_state == LOCKOUT);
        e_siren  = (m_state == ALARM_ON) || (m_state == ALARM_HOLD);
        checks++;
        if (state !== m_state || status !== e_status || siren_en !== e_siren ||
            zone !== 1'(m_zone) || countdown !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL model_cmp t=%0t got st=%0d stat=%0b sir=%0b zone=%0d cd=%0d want st=%0d stat=%0b sir=%0b zone=%0d cd=%0d",
                     $time, state, status, siren_en, zone, countdown,
                     m_state, e_status, e_siren, m_zone, m_cnt);
        end
    end

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; clk1();
            tick_1hz = 1'b0; clk1();
        end
    endtask

    task automatic full_cycle(input logic [N-1:0] pat, input int trig_len, input int exp_zone);
        doors = pat; clk1();
        expect_eq("cyc_trig_state", state, 2);
        expect_eq("cyc_trig_cd", countdown, trig_len);
        expect_eq("cyc_trig_zone", zone, exp_zone);
        ticks(trig_len);
        expect_eq("cyc_on_state", state, 3);
        doors = '0; clk1();
        expect_eq("cyc_hold_cd", countdown, 10);
        ticks(10);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        clk1();
        expect_eq("rst_state", state, 0);
        expect_eq("rst_cd", countdown, 0);
        expect_eq("rst_zone", zone, 0);
        expect_eq("rst_status", status, 1);
        expect_eq("rst_siren", siren_en, 0);

        doors = 2'b10; clk1();
        expect_eq("t1_state", state, 2);
        expect_eq("t1_zone", zone, 1);
        expect_eq("t1_cd", countdown, 15);
        ticks(14);
        expect_eq("t1_cd_14", countdown, 1);
        expect_eq("t1_state_14", state, 2);
        ticks(1);
        expect_eq("t1_alarm", state, 3);
        expect_eq("t1_siren", siren_en, 1);

        doors = '0; clk1();
        expect_eq("t2_hold", state, 4);
        expect_eq("t2_hold_cd", countdown, 10);
        ticks(4);
        expect_eq("t2_cd_6", countdown, 6);
        doors = 2'b01; clk1();
        expect_eq("t2_reopen", state, 3);
        doors = '0; clk1();
        ticks(10);
        expect_eq("t3_c1_armed", state, 0);

        full_cycle(2'b01, 8, 0);
        expect_eq("t3_c2_armed", state, 0);
        full_cycle(2'b10, 15, 1);
        expect_eq("t3_lockout", state, 5);
        expect_eq("t3_lock_status", status, 1);
        expect_eq("t3_lock_siren", siren_en, 0);
        doors = 2'b11; clk1(); clk1();
        expect_eq("t3_lock_ignore", state, 5);
        expect_eq("t3_lock_zone", zone, 1);

        ignition = 1'b1; clk1();
        expect_eq("t4_disarmed", state, 1);
        expect_eq("t4_status", status, 0);
        ignition = 1'b0; doors = '0; clk1();
        doors = 2'b01; clk1();
        doors = '0; clk1();
        expect_eq("t4_delay_cd", countdown, 6);
        ticks(3);
        expect_eq("t4_cd_3", countdown, 3);
        doors = 2'b01; clk1();
        doors = '0; clk1();
        expect_eq("t4_reload", countdown, 6);
        ticks(5);
        expect_eq("t4_still_dis", state, 1);
        ticks(1);
        expect_eq("t4_armed", state, 0);
        expect_eq("t4_armed_status", status, 1);

        sel = 2'd1; value = '0; reprogram = 1'b1; clk1(); reprogram = 1'b0;
        doors = 2'b01; clk1();
        expect_eq("t5_cd_1", countdown, 1);
        ticks(1);
        expect_eq("t5_alarm", state, 3);
        doors = '0; sel = 2'd3; value = 4'd10; reprogram = 1'b1; clk1(); reprogram = 1'b0;
        expect_eq("t5_reprog_armed", state, 0);
        expect_eq("t5_reprog_cd", countdown, 0);
        ignition = 1'b1; doors = 2'b10; clk1();
        expect_eq("t5_ign_wins", state, 1);

        ignition = 1'b0; doors = '0; sel = 2'd2; value = 4'd3; reprogram = 1'b1; clk1(); reprogram = 1'b0;
        doors = 2'b10; clk1();
        expect_eq("t6_cd_3", countdown, 3);
        #2 reset_n = 1'b0;
        #1;
        expect_eq("t6_async_state", state, 0);
        expect_eq("t6_async_cd", countdown, 0);
        expect_eq("t6_async_zone", zone, 0);
        doors5 = 5'b10100;
        #2 reset_n = 1'b1;
        clk1();
        expect_eq("t6_default_cd", countdown, 15);
        expect_eq("n5_zone", zone5, 2);
        expect_eq("n5_cd", countdown5, 15);
        expect_eq("n1_state", state1, 0);
        expect_eq("n1_zone", zone1, 0);
        doors5 = '0;

        for (int c = 0; c < 15000; c++) begin
            tick_1hz = ($urandom_range(0, 2) == 0);
            if (ignition) begin
                if ($urandom_range(0, 14) == 0) ignition = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                ignition = 1'b1;
            end
            for (int b = 0; b < N; b++) if ($urandom_range(0, 29) == 0) doors[b] = ~doors[b];
            reprogram = ($urandom_range(0, 299) == 0);
            sel   = 2'($urandom_range(0, 3));
            value = CW'($urandom_range(0, 15));
            clk1();
        end
        reprogram = 1'b0;
        clk1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
